imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 42 ++++
 rtl/instr_encode.sv | 27 ++
 rtl/imem_loader.sv | 117 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared encoding formats, loader states and opcode/funct constants
package imem_loader_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_RSV = 2'd3
   } fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // True when the fields describe something the main or ALU decoder cannot execute.
   function automatic logic field_bad(input logic [1:0] fmt, input logic [5:0] op,
                                      input logic [5:0] funct);
      logic op_ok;
      logic funct_ok;
      op_ok    = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                 (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
      funct_ok = (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
                 (funct == FUNCT_OR) || (funct == FUNCT_SLT);
      return !op_ok || (fmt == FMT_RSV) || ((op == OP_RTYPE) && !funct_ok);
   endfunction

endpackage

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - packs instruction fields into a 32-bit word by format
module instr_encode
   import imem_loader_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word
);

   // The reserved format falls through to the R layout.
   always_comb begin
      word = {op, rs, rt, rd, shamt, funct};
      case (fmt_t'(fmt))
         FMT_I:   word = {op, rs, rt, imm};
         FMT_J:   word = {op, target};
         default: ;
      endcase
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams encoded instructions into instruction memory, then releases the CPU
// Optional field checking is enabled by defining LOADER_CHECK_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    fmt,
   input  logic [5:0]    op,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [4:0]    shamt,
   input  logic [5:0]    funct,
   input  logic [15:0]   imm,
   input  logic [25:0]   target,
   input  logic          last,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [31:0]   wdata,
   output logic          cpu_reset,
   output logic          done,
   output logic [AW:0]   count,
   output logic          err
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   state_t      state;
   state_t      state_nx;
   logic        hs;
   logic        fin;
   logic        restart;
   logic [31:0] word;

   instr_encode u_encode (
      .fmt    (fmt),
      .op     (op),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .funct  (funct),
      .imm    (imm),
      .target (target),
      .word   (word)
   );

   // Derived from state directly so in_ready and the handshake stay out of one comb loop.
   assign hs      = in_valid && (state == ST_LOAD);
   assign fin     = hs && (last || ((count + CNT_ONE) == CNT_FULL));
   assign restart = start && (state != ST_LOAD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      done      = 1'b0;
      cpu_reset = 1'b1;
      case (state)
         ST_IDLE: if (start) state_nx = ST_LOAD;
         ST_LOAD: begin
            in_ready = 1'b1;
            if (fin) state_nx = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            cpu_reset = err;
            if (start) state_nx = ST_LOAD;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         count <= '0;
      end else begin
         we <= hs;
         if (hs) begin
            waddr <= count[AW-1:0];
            wdata <= word;
            count <= count + CNT_ONE;
         end else if (restart) begin
            count <= '0;
         end
      end
   end

`ifdef LOADER_CHECK_EN
   logic bad;
   assign bad = field_bad(fmt, op, funct);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          err <= 1'b0;
      else if (restart)   err <= 1'b0;
      else if (hs && bad) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
